// File: rtl/uart_rx_unit_pkg.sv
// Definitions shared by the UART receive and transmit paths: state encoding,
// frame geometry and the oversample divisor.
package uart_rx_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        int div_v;
        div_v = (clk_freq + (OVERSAMPLE / 2) * baud_rate) / (OVERSAMPLE * baud_rate);
        return (div_v < 1) ? 1 : div_v;
    endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Consumer-facing side of the receiver: holding register and avail/ack handshake.
interface uart_rx_unit_if;
    import uart_rx_unit_pkg::*;

    logic                 rx_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_avail;
    logic                 rx_error;
    logic                 rx_overrun;
    logic                 rx_busy;

    modport master (
        input  rx_ack,
        output rx_data, rx_avail, rx_error, rx_overrun, rx_busy
    );

    modport slave (
        output rx_ack,
        input  rx_data, rx_avail, rx_error, rx_overrun, rx_busy
    );

endinterface

// File: rtl/uart_rx_unit_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, realigned to zero
// by a synchronous restart so sampling follows the start edge.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // Next divider value: wrap at LAST, forced to zero on restart.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (restart || (cnt_r == LAST)) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Divider register; tick is registered alongside so it decodes cnt_r == LAST.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= '0;
            tick_r <= (LAST == '0);
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 16x oversampled start/data/stop sampling feeding a
// one-deep holding register with avail/ack handshake and sticky overrun.
module uart_rx_unit
    import uart_rx_unit_pkg::*;
#(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 57600
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    uart_rx_unit_if.master bus
);
    localparam int DIV = calc_div(clk_freq, baud_rate);

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e          state_r, state_nxt_s;
    logic                 sync1_r, sync2_r;
    logic [3:0]           tick_cnt_r, tick_cnt_nxt_s;
    logic [2:0]           bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic [DATA_BITS-1:0] data_r, data_nxt_s;
    logic                 avail_r, avail_nxt_s;
    logic                 overrun_r, overrun_nxt_s;
    logic                 error_r, error_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 restart_s;
    logic                 tick_s;
    logic                 rxs_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    assign rxs_s = sync2_r;

    // Two-flop synchronizer on the raw line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, sampling and holding-register logic.
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        data_nxt_s     = data_r;
        avail_nxt_s    = avail_r;
        overrun_nxt_s  = overrun_r;
        error_nxt_s    = 1'b0;
        restart_s      = 1'b0;

        if (bus.rx_ack && avail_r) begin
            avail_nxt_s   = 1'b0;
            overrun_nxt_s = 1'b0;
        end else begin
            avail_nxt_s   = avail_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_nxt_s    = ST_START;
                    tick_cnt_nxt_s = 4'd0;
                    restart_s      = 1'b1;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tick_cnt_r == MID_TICK)) begin
                    // A line back high at mid start bit was only a glitch.
                    state_nxt_s    = rxs_s ? ST_IDLE : ST_DATA;
                    tick_cnt_nxt_s = 4'd0;
                    bit_cnt_nxt_s  = 3'd0;
                end else if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == LAST_TICK) begin
                        shift_nxt_s   = {rxs_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        state_nxt_s   = (bit_cnt_r == LAST_BIT) ? ST_STOP : ST_DATA;
                    end else begin
                        state_nxt_s   = ST_DATA;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == LAST_TICK) begin
                        state_nxt_s = ST_IDLE;
                        if (rxs_s) begin
                            // A coincident ack frees the slot, so no overrun.
                            data_nxt_s  = shift_r;
                            avail_nxt_s = 1'b1;
                            if (avail_r && !bus.rx_ack) begin
                                overrun_nxt_s = 1'b1;
                            end else begin
                                overrun_nxt_s = overrun_nxt_s;
                            end
                        end else begin
                            error_nxt_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= '0;
            data_r     <= '0;
            avail_r    <= 1'b0;
            overrun_r  <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            data_r     <= data_nxt_s;
            avail_r    <= avail_nxt_s;
            overrun_r  <= overrun_nxt_s;
            error_r    <= error_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign bus.rx_data    = data_r;
    assign bus.rx_avail   = avail_r;
    assign bus.rx_error   = error_r;
    assign bus.rx_overrun = overrun_r;
    assign bus.rx_busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit at 16 clocks per bit (DIV=1): frames are
// predicted from 8N1 rules when sent, and a monitor checks every delivery.
module tb_uart_rx_unit;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         ovr;
        int         t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    exp_t       exp_q[$];

    // Consumer-visible model: unread byte present, sticky overrun, last byte.
    bit         unread_m;
    bit         ovr_m;
    logic [7:0] last_m;

    logic       prev_avail;
    logic       prev_err;
    logic [7:0] prev_data;

    uart_rx_unit_if bus_if();

    uart_rx_unit #(.clk_freq(1600000), .baud_rate(100000)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL timeout: cycle budget exhausted, errors=%0d", errors);
            $fatal(1, "timeout");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat);
        checks++;
        if (lat < 154 || lat > 156) begin
            errors++;
            $display("FAIL %s: latency %0d cycles expected 155 +/-1", name, lat);
        end
    endtask

    // Monitor: every byte delivery or error pulse is matched against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_if.rx_error) begin
                check("err_pulse_width", {31'd0, prev_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_error", 32'd1, 32'd0);
                end else begin
                    check("event_is_error", {31'd0, exp_q[0].is_err}, 32'd1);
                    check_lat("error_latency", cyc - exp_q[0].t0);
                    void'(exp_q.pop_front());
                end
            end
            if (bus_if.rx_avail && (!prev_avail || bus_if.rx_data !== prev_data)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, bus_if.rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("event_is_byte", {31'd0, exp_q[0].is_err}, 32'd0);
                    check("rx_data", {24'd0, bus_if.rx_data}, {24'd0, exp_q[0].data});
                    check("rx_overrun", {31'd0, bus_if.rx_overrun}, {31'd0, exp_q[0].ovr});
                    check_lat("byte_latency", cyc - exp_q[0].t0);
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_avail <= bus_if.rx_avail;
        prev_err   <= bus_if.rx_error;
        prev_data  <= bus_if.rx_data;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus_if.rx_ack = 1'b1;
        @(negedge clk);
        bus_if.rx_ack = 1'b0;
        check("ack_clears_avail", {31'd0, bus_if.rx_avail}, 32'd0);
        check("ack_clears_overrun", {31'd0, bus_if.rx_overrun}, 32'd0);
        unread_m = 1'b0;
        ovr_m    = 1'b0;
    endtask

    // One 160-cycle frame; ack_at pulses rx_ack at that cycle index (154 lands
    // on the completion cycle), rst_at pulls reset low for two cycles.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int ack_at,
                              input int rst_at, output int t_start);
        logic [9:0] f;
        exp_t       e;
        f = {stop_bit, d, 1'b0};
        e.is_err = !stop_bit;
        e.data   = d;
        e.ovr    = 1'b0;
        if (ack_at >= 0 && ack_at <= 154) begin
            unread_m = 1'b0;
            ovr_m    = 1'b0;
        end
        if (rst_at < 0 && stop_bit) begin
            if (unread_m) ovr_m = 1'b1;
            unread_m = 1'b1;
            last_m   = d;
            e.ovr    = ovr_m;
        end
        t_start = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            rxd = f[i / 16];
            bus_if.rx_ack = (i == ack_at);
            if (i == 0) begin
                t_start = cyc;
                e.t0    = cyc;
                if (rst_at < 0) exp_q.push_back(e);
            end
            if (rst_at >= 0 && i == rst_at) rst = 1'b0;
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("rst_rx_data", {24'd0, bus_if.rx_data}, 32'd0);
                check("rst_rx_avail", {31'd0, bus_if.rx_avail}, 32'd0);
                check("rst_rx_error", {31'd0, bus_if.rx_error}, 32'd0);
                check("rst_rx_overrun", {31'd0, bus_if.rx_overrun}, 32'd0);
                check("rst_rx_busy", {31'd0, bus_if.rx_busy}, 32'd0);
                unread_m = 1'b0;
                ovr_m    = 1'b0;
                last_m   = 8'h00;
            end
            if (rst_at >= 0 && i == rst_at + 2) rst = 1'b1;
        end
        bus_if.rx_ack = 1'b0;
    endtask

    initial begin
        int         ts;
        int         ack_at;
        logic [7:0] d;
        bit         stop_bit;

        rst = 1'b0;
        rxd = 1'b1;
        bus_if.rx_ack = 1'b0;
        unread_m = 1'b0;
        ovr_m    = 1'b0;
        last_m   = 8'h00;
        repeat (3) @(negedge clk);
        check("init_rx_data", {24'd0, bus_if.rx_data}, 32'd0);
        check("init_rx_avail", {31'd0, bus_if.rx_avail}, 32'd0);
        check("init_rx_error", {31'd0, bus_if.rx_error}, 32'd0);
        check("init_rx_overrun", {31'd0, bus_if.rx_overrun}, 32'd0);
        check("init_rx_busy", {31'd0, bus_if.rx_busy}, 32'd0);
        rst = 1'b1;
        idle(10);

        // Single byte, then back-to-back 0x00/0xFF with the first acked mid-frame.
        send_frame(8'hA5, 1'b1, -1, -1, ts);
        idle(4);
        do_ack();
        idle(5);
        send_frame(8'h00, 1'b1, -1, -1, ts);
        send_frame(8'hFF, 1'b1, 20, -1, ts);
        idle(4);
        do_ack();

        // 5-cycle glitch must fall back to idle with no delivery.
        idle(10);
        repeat (5) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        @(negedge clk);
        rxd = 1'b1;
        for (int k = 0; k < 10 && !bus_if.rx_busy; k++) @(negedge clk);
        check("glitch_busy_rise", {31'd0, bus_if.rx_busy}, 32'd1);
        for (int k = 0; k < 30 && bus_if.rx_busy; k++) @(negedge clk);
        check("glitch_busy_fall", {31'd0, bus_if.rx_busy}, 32'd0);
        check("glitch_no_avail", {31'd0, bus_if.rx_avail}, 32'd0);

        // Framing error, then a good byte.
        idle(10);
        send_frame(8'h3C, 1'b0, -1, -1, ts);
        idle(24);
        check("ferr_no_avail", {31'd0, bus_if.rx_avail}, 32'd0);
        send_frame(8'h81, 1'b1, -1, -1, ts);
        idle(4);
        do_ack();

        // Overrun without ack, then the same with ack on the completion cycle.
        idle(5);
        send_frame(8'h11, 1'b1, -1, -1, ts);
        send_frame(8'h22, 1'b1, -1, -1, ts);
        idle(4);
        check("overrun_sticky", {31'd0, bus_if.rx_overrun}, 32'd1);
        do_ack();
        idle(5);
        send_frame(8'h11, 1'b1, -1, -1, ts);
        send_frame(8'h22, 1'b1, 154, -1, ts);
        idle(4);
        check("coinc_no_overrun", {31'd0, bus_if.rx_overrun}, 32'd0);
        check("coinc_avail_kept", {31'd0, bus_if.rx_avail}, 32'd1);

        // Reset during bit 3 of 0x5A. The 0 in bit 5 of the abandoned frame then
        // looks like a fresh start edge: that frame samples bit6, bit7, the stop
        // bit and idle ones, giving 0xFD with a good stop bit after the 5A frame ends.
        idle(5);
        send_frame(8'h5A, 1'b1, -1, 70, ts);
        check("abandoned_frame_no_avail", {31'd0, bus_if.rx_avail}, 32'd0);
        exp_q.push_back('{is_err: 1'b0, data: 8'hFD, ovr: 1'b0, t0: ts + 96});
        unread_m = 1'b1;
        last_m   = 8'hFD;
        idle(120);
        do_ack();
        idle(5);
        send_frame(8'hC3, 1'b1, -1, -1, ts);
        idle(4);
        do_ack();

        // Randomized frames, ack placement and framing errors.
        for (int n = 0; n < 16; n++) begin
            d        = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0:       ack_at = -1;
                1:       ack_at = $urandom_range(0, 150);
                default: ack_at = 154;
            endcase
            if (unread_m && (ack_at < 0 || ack_at == 154) && d == last_m) d = d ^ 8'h01;
            send_frame(d, stop_bit, ack_at, -1, ts);
            if (!stop_bit) idle(24);
            else idle($urandom_range(0, 10));
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        for (int k = 0; k < 400 && exp_q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
